// File: rtl/fnd_scan_driver.sv
// Multiplexed N-digit 7-segment driver: shadowed digit word, hex/dash glyphs,
// decimal points, blanking, leading-zero suppression and an anti-ghost guard.
module fnd_scan_driver #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000,
  parameter int GUARD    = 2,
  localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1,
  localparam int PRE_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   digits_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank_in,
  input  logic                  hex_mode,
  input  logic                  lz_en,
  output logic [6:0]            seg_out,
  output logic                  dp_out,
  output logic [DIGITS-1:0]     an_out,
  output logic [IDX_W-1:0]      scan_idx
);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [PRE_W-1:0] GUARD_V  = PRE_W'(GUARD);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  function automatic logic [6:0] glyph(input logic [3:0] code, input logic hex);
    logic [6:0] g;
    case (code)
      4'h0: g = 7'b0000001;
      4'h1: g = 7'b1001111;
      4'h2: g = 7'b0010010;
      4'h3: g = 7'b0000110;
      4'h4: g = 7'b1001100;
      4'h5: g = 7'b0100100;
      4'h6: g = 7'b0100000;
      4'h7: g = 7'b0001111;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0000100;
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b1100000;
      4'hC: g = 7'b0110001;
      4'hD: g = 7'b1000010;
      4'hE: g = 7'b0110000;
      default: g = 7'b0111000;
    endcase
    if (!hex && code > 4'd9)
      g = 7'b1111110;
    return g;
  endfunction

  logic [PRE_W-1:0]    pre_p0;
  logic [IDX_W-1:0]    idx_p0;
  logic [4*DIGITS-1:0] digits_p0;
  logic [DIGITS-1:0]   dp_p0;
  logic [DIGITS-1:0]   blank_p0;

  logic [3:0]          codes [DIGITS];
  logic [DIGITS-1:0]   lz_sup;
  logic                zero_run;
  logic                dark;
  logic [DIGITS-1:0]   an_next;
  logic [6:0]          seg_next;
  logic                dp_next;

  logic [DIGITS-1:0]   an_p1;
  logic [6:0]          seg_p1;
  logic                dp_p1;

  // Stage p0 -> p1: decode the current slot from the shadow word
  always_comb begin
    lz_sup   = '0;
    zero_run = 1'b1;
    for (int i = 0; i < DIGITS; i++)
      codes[i] = digits_p0[4*i +: 4];
    // A digit is suppressed only when it and every digit to its left are zero
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_run  = zero_run & (codes[i] == 4'd0);
      lz_sup[i] = lz_en & zero_run;
    end
    dark     = (pre_p0 < GUARD_V) | blank_p0[idx_p0] | lz_sup[idx_p0];
    an_next  = dark ? '1 : ~(DIGITS'(1) << idx_p0);
    seg_next = dark ? 7'b1111111 : glyph(codes[idx_p0], hex_mode);
    dp_next  = dark ? 1'b1 : ~dp_p0[idx_p0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_p0    <= '0;
      idx_p0    <= '0;
      digits_p0 <= '0;
      dp_p0     <= '0;
      blank_p0  <= '0;
      an_p1     <= '1;
      seg_p1    <= 7'b1111111;
      dp_p1     <= 1'b1;
    end else begin
      if (pre_p0 == PRE_LAST) begin
        pre_p0 <= '0;
        idx_p0 <= (idx_p0 == IDX_LAST) ? '0 : idx_p0 + 1'b1;
      end else begin
        pre_p0 <= pre_p0 + 1'b1;
      end
      if (load) begin
        digits_p0 <= digits_in;
        dp_p0     <= dp_in;
        blank_p0  <= blank_in;
      end
      an_p1  <= an_next;
      seg_p1 <= seg_next;
      dp_p1  <= dp_next;
    end
  end

  assign an_out   = an_p1;
  assign seg_out  = seg_p1;
  assign dp_out   = dp_p1;
  assign scan_idx = idx_p0;

endmodule

// File: tb/tb_fnd_scan_driver.sv
// Scoreboard bench for fnd_scan_driver (4 digits, 8-cycle slots, 2-cycle guard).
module tb_fnd_scan_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic [3:0]  blank_in;
  logic        hex_mode;
  logic        lz_en;
  logic [6:0]  seg_out;
  logic        dp_out;
  logic [3:0]  an_out;
  logic [1:0]  scan_idx;

  fnd_scan_driver #(.DIGITS(4), .SCAN_DIV(8), .GUARD(2)) dut (
    .clk(clk), .rst(rst), .load(load), .digits_in(digits_in), .dp_in(dp_in),
    .blank_in(blank_in), .hex_mode(hex_mode), .lz_en(lz_en), .seg_out(seg_out),
    .dp_out(dp_out), .an_out(an_out), .scan_idx(scan_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    int         idx;
    string      name;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   t0, t1;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation that falls due in this cycle
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      cur = q.pop_front();
      n_checks++;
      if (cur.cyc < cyc) begin
        $display("FAIL %s: expectation for cycle %0d missed (now %0d)", cur.name, cur.cyc, cyc);
      end else if (an_out === cur.an && seg_out === cur.seg && dp_out === cur.dp &&
                   (cur.idx < 0 || int'(scan_idx) == cur.idx)) begin
        n_pass++;
      end else begin
        $display("FAIL %s @%0d: got an=%b seg=%b dp=%b idx=%0d, want an=%b seg=%b dp=%b idx=%0d",
                 cur.name, cyc, an_out, seg_out, dp_out, scan_idx, cur.an, cur.seg, cur.dp, cur.idx);
      end
    end
  end

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_at(input int c, input logic [3:0] an, input logic [6:0] seg,
                           input logic dp, input int idx, input string name);
    exp_t e;
    e.cyc = c; e.an = an; e.seg = seg; e.dp = dp; e.idx = idx; e.name = name;
    q.push_back(e);
  endtask

  task automatic expect_dark(input int c, input int idx, input string name);
    expect_at(c, 4'b1111, 7'b1111111, 1'b1, idx, name);
  endtask

  // Mid-slot sample: pre=4 of slot k in frame f, relative to t0
  task automatic slot(input int f, input int k, input logic [6:0] seg, input logic dp,
                      input string name);
    expect_at(t0 + f*32 + k*8 + 5, ~(4'b0001 << k), seg, dp, k, name);
  endtask

  task automatic slot_dark(input int f, input int k, input string name);
    expect_dark(t0 + f*32 + k*8 + 5, k, name);
  endtask

  task automatic do_load(input int c, input logic [15:0] d, input logic [3:0] dp,
                         input logic [3:0] bl);
    goto(c);
    load = 1'b1; digits_in = d; dp_in = dp; blank_in = bl;
    goto(c + 1);
    load = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; load = 1'b0; digits_in = '0; dp_in = '0; blank_in = '0;
    hex_mode = 1'b1; lz_en = 1'b0;
    t0 = 3;
    // Reset and slot timing (shadow is all zero, so every digit shows 0)
    expect_dark(1, 0, "reset_c1");
    expect_dark(2, 0, "reset_c2");
    expect_dark(t0 + 0, 0, "rel0_inactive");
    expect_at(t0 + 3,  4'b1110, 7'b0000001, 1'b1, 0, "d0_first");
    expect_at(t0 + 8,  4'b1110, 7'b0000001, 1'b1, 1, "d0_last");
    expect_dark(t0 + 9, 1, "guard1_a");
    expect_dark(t0 + 10, 1, "guard1_b");
    expect_at(t0 + 11, 4'b1101, 7'b0000001, 1'b1, 1, "d1_first");
    expect_at(t0 + 27, 4'b0111, 7'b0000001, 1'b1, 3, "d3_first");
    expect_at(t0 + 32, 4'b0111, 7'b0000001, 1'b1, 0, "d3_last");
    expect_at(t0 + 35, 4'b1110, 7'b1001100, 1'b1, 0, "d0_frame1");
    goto(t0);
    rst = 1'b0;

    // Frame 1: 1234 decimal
    do_load(t0 + 31, 16'h1234, 4'b0000, 4'b0000);
    slot(1, 0, 7'b1001100, 1'b1, "f1_d0_4");
    slot(1, 1, 7'b0000110, 1'b1, "f1_d1_3");
    slot(1, 2, 7'b0010010, 1'b1, "f1_d2_2");
    slot(1, 3, 7'b1001111, 1'b1, "f1_d3_1");

    // Frame 2: ABCD hex glyphs; frame 3: same word as dashes
    do_load(t0 + 63, 16'hABCD, 4'b0000, 4'b0000);
    slot(2, 0, 7'b1000010, 1'b1, "f2_d0_d");
    slot(2, 1, 7'b0110001, 1'b1, "f2_d1_C");
    slot(2, 3, 7'b0001000, 1'b1, "f2_d3_A");
    slot(3, 0, 7'b1111110, 1'b1, "f3_d0_dash");
    slot(3, 1, 7'b1111110, 1'b1, "f3_d1_dash");
    slot(3, 2, 7'b1111110, 1'b1, "f3_d2_dash");
    slot(3, 3, 7'b1111110, 1'b1, "f3_d3_dash");
    goto(t0 + 95);
    hex_mode = 1'b0;

    // Frames 4-6: leading-zero suppression
    slot(4, 0, 7'b0001111, 1'b1, "f4_d0_7");
    slot_dark(4, 1, "f4_d1_lz");
    slot_dark(4, 2, "f4_d2_lz");
    slot_dark(4, 3, "f4_d3_lz");
    goto(t0 + 127);
    hex_mode = 1'b1;
    lz_en = 1'b1;
    do_load(t0 + 127, 16'h0007, 4'b0000, 4'b0000);

    slot(5, 0, 7'b0000001, 1'b1, "f5_d0_zero");
    slot_dark(5, 1, "f5_d1_lz");
    slot_dark(5, 3, "f5_d3_lz");
    do_load(t0 + 159, 16'h0000, 4'b0000, 4'b0000);

    slot(6, 0, 7'b0000001, 1'b1, "f6_d0_0");
    slot(6, 1, 7'b0000001, 1'b1, "f6_d1_0");
    slot(6, 2, 7'b1001111, 1'b1, "f6_d2_1");
    slot_dark(6, 3, "f6_d3_lz");
    do_load(t0 + 191, 16'h0100, 4'b0000, 4'b0000);

    // Frame 7: decimal point and blanking
    slot_dark(7, 0, "f7_d0_blank");
    slot(7, 1, 7'b0001111, 1'b1, "f7_d1_7");
    slot(7, 2, 7'b0100000, 1'b0, "f7_d2_6_dp");
    slot(7, 3, 7'b0100100, 1'b1, "f7_d3_5");
    goto(t0 + 223);
    lz_en = 1'b0;
    do_load(t0 + 223, 16'h5678, 4'b0100, 4'b0001);

    // Frame 8: mid-slot load, then reset mid-slot
    t1 = t0 + 279;
    expect_at(t0 + 260, 4'b1110, 7'b1001100, 1'b1, 0, "f8_d0_4");
    expect_at(t0 + 269, 4'b1101, 7'b0000110, 1'b1, 1, "f8_d1_before");
    expect_at(t0 + 270, 4'b1101, 7'b0000100, 1'b1, 1, "f8_d1_after");
    expect_at(t0 + 272, 4'b1101, 7'b0000100, 1'b1, 2, "f8_d1_end");
    expect_at(t0 + 277, 4'b1011, 7'b0000100, 1'b1, 2, "f8_d2_9");
    expect_dark(t0 + 278, 0, "rst_next_cycle");
    expect_dark(t0 + 279, 0, "rst_hold");
    expect_dark(t1 + 2, 0, "post_rst_guard");
    expect_at(t1 + 5, 4'b1110, 7'b0000001, 1'b1, 0, "post_rst_d0");
    expect_at(t1 + 13, 4'b1101, 7'b0000001, 1'b1, 1, "post_rst_d1");
    do_load(t0 + 255, 16'h1234, 4'b0000, 4'b0000);
    do_load(t0 + 268, 16'h9999, 4'b0000, 4'b0000);
    goto(t0 + 277);
    rst = 1'b1;
    goto(t1);
    rst = 1'b0;

    goto(t1 + 16);
    while (q.size() > 0) begin
      cur = q.pop_front();
      n_checks++;
      $display("FAIL %s: expectation for cycle %0d never compared", cur.name, cur.cyc);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
